// File: rtl/or_16.sv
// or_16: bitwise OR of two operands, with combinational result/reductions and a registered, valid-tagged copy
module or_16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             out_valid,
  output logic             out_any,
  output logic             out_all
);
  logic [WIDTH-1:0] data_d, data_q;
  logic             valid_d, valid_q;
  assign out     = a | b;
  assign out_any = |out;
  assign out_all = &out;
  always_comb begin
    data_d  = in_valid ? out : data_q;
    valid_d = in_valid;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end
  assign out_q     = data_q;
  assign out_valid = valid_q;
endmodule

// File: tb/tb_or_16.sv
// tb_or_16: randomized scoreboard bench for or_16 (combinational and registered paths)
module tb_or_16;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        in_valid = 1'b0;
  logic [15:0] out, out_q;
  logic        out_valid, out_any, out_all;
  int          checks = 0;
  int          failures = 0;
  logic [15:0] sb[$];
  logic        started = 1'b0;
  logic        done = 1'b0;

  or_16 #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .in_valid(in_valid),
    .out(out), .out_q(out_q), .out_valid(out_valid),
    .out_any(out_any), .out_all(out_all)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [15:0] x, input logic [15:0] y);
    logic [15:0] e;
    @(negedge clk);
    reset = r; in_valid = v; a = x; b = y;
    #1;
    e = x | y;
    checks++;
    if (out !== e) begin
      failures++;
      $display("FAIL out: a=%b, b=%b, out=%b expected %b", x, y, out, e);
    end
    chk("out_any", {15'd0, out_any}, {15'd0, e != 16'h0000});
    chk("out_all", {15'd0, out_all}, {15'd0, e == 16'hFFFF});
    if (v && !r) sb.push_back(e);
  endtask

  initial begin : monitor
    logic        r, v;
    logic [15:0] held;
    held = '0;
    while (!done) begin
      @(posedge clk);
      r = reset; v = in_valid;
      #1;
      if (r) begin
        started = 1'b1;
        held = '0;
        chk("reset_out_q", out_q, 16'h0000);
        chk("reset_out_valid", {15'd0, out_valid}, 16'd0);
      end else if (started) begin
        chk("out_valid", {15'd0, out_valid}, {15'd0, v});
        if (v) begin
          if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL scoreboard_empty: got result %h expected none", out_q);
          end else held = sb.pop_front();
        end
        chk("out_q", out_q, held);
      end
    end
  end

  initial begin
    int f0;
    drive(1, 0, 16'h0000, 16'h0000);
    drive(0, 0, 16'h0000, 16'h0000);
    drive(0, 0, 16'hFF00, 16'h00FF);
    chk("dir_ff00_00ff", out, 16'hFFFF);
    drive(0, 0, 16'hA5A5, 16'h5A5A);
    chk("dir_a5a5_5a5a", out, 16'hFFFF);
    drive(1, 0, 16'h0000, 16'h0000);
    drive(0, 1, 16'h1234, 16'h0F0F);
    drive(0, 0, 16'h0000, 16'h0000);
    chk("dir_cap_out_q", out_q, 16'h1F3F);
    chk("dir_cap_valid", {15'd0, out_valid}, 16'd1);
    drive(0, 0, 16'h0000, 16'h0000);
    chk("dir_hold_out_q", out_q, 16'h1F3F);
    chk("dir_hold_valid", {15'd0, out_valid}, 16'd0);
    drive(1, 1, 16'hFFFF, 16'h0000);
    drive(0, 0, 16'hFFFF, 16'h0000);
    chk("dir_rst_win_out_q", out_q, 16'h0000);
    chk("dir_rst_win_valid", {15'd0, out_valid}, 16'd0);
    chk("dir_rst_win_out", out, 16'hFFFF);
    drive(0, 1, 16'h0001, 16'h8000);
    drive(0, 1, 16'h0F00, 16'h00F0);
    drive(0, 1, 16'h0000, 16'h0000);
    f0 = failures;
    for (int i = 0; i < 10000; i++) begin
      logic [15:0] x, y;
      x = 16'($urandom);
      y = 16'($urandom);
      case ($urandom_range(0, 7))
        0: y = ~x;
        1: begin x = '0; y = '0; end
        default: ;
      endcase
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1, x, y);
    end
    if (failures == f0) $display("random pairs passed");
    drive(0, 0, 16'h0000, 16'h0000);
    drive(0, 0, 16'h0000, 16'h0000);
    done = 1'b1;
    chk("scoreboard_drained", 16'(sb.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
